// File: rtl/gb_memmap_banked.sv
// CPU address decoder with boot-ROM latch, VRAM bank and WRAM bank registers.
// Fences the cartridge/VRAM/WRAM/OAM/boot regions while OAM DMA owns the bus.
module gb_memmap_banked #(
   parameter int CGB         = 0,
   parameter int WRAM_BANKS  = 2,
   parameter int VRAM_BANKS  = 1,
   parameter int BOOT_ENABLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] adr,
   input  logic        rd,
   input  logic        wr,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        dout_en,
   input  logic        dma_active,
   output logic        sel_bootrom,
   output logic        sel_cartridge,
   output logic        sel_vram,
   output logic        sel_ram,
   output logic        sel_oam,
   output logic        sel_hram,
   output logic        sel_io,
   output logic        vram_bank,
   output logic [2:0]  ram_bank,
   output logic        bus_conflict
);

   localparam bit IS_CGB     = (CGB == 1);
   localparam bit HAS_WBANK  = (WRAM_BANKS == 8);
   localparam bit HAS_VBANK  = (VRAM_BANKS == 2);
   localparam bit BOOT_RESET = (BOOT_ENABLE == 0);

   if (CGB != 0 && CGB != 1) begin : g_bad_cgb
      $error("gb_memmap_banked: CGB must be 0 or 1");
   end
   if (WRAM_BANKS != 2 && WRAM_BANKS != 8) begin : g_bad_wram
      $error("gb_memmap_banked: WRAM_BANKS must be 2 or 8");
   end
   if (VRAM_BANKS != 1 && VRAM_BANKS != 2) begin : g_bad_vram
      $error("gb_memmap_banked: VRAM_BANKS must be 1 or 2");
   end
   if (CGB == 0 && (WRAM_BANKS == 8 || VRAM_BANKS == 2)) begin : g_bad_dmg
      $error("gb_memmap_banked: banked WRAM/VRAM requires CGB=1");
   end
   if (BOOT_ENABLE != 0 && BOOT_ENABLE != 1) begin : g_bad_boot
      $error("gb_memmap_banked: BOOT_ENABLE must be 0 or 1");
   end

   typedef enum logic [3:0] {
      RGN_NONE,
      RGN_BOOT,
      RGN_CART,
      RGN_VRAM,
      RGN_RAM,
      RGN_OAM,
      RGN_HRAM,
      RGN_IO,
      RGN_BOOTOFF,
      RGN_VBK,
      RGN_SVBK
   } region_t;

   region_t    region;
   logic       boot_done;
   logic       vbk;
   logic [2:0] svbk;
   logic       in_boot;
   logic       fenced;
   logic       unused_din;

   assign unused_din = ^din[7:3];

   // Mapping registers; a write is seen by decode only from the next cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         boot_done <= BOOT_RESET;
         vbk       <= 1'b0;
         svbk      <= 3'd0;
      end else if (wr) begin
         if (region == RGN_BOOTOFF && din[0]) begin
            boot_done <= 1'b1;
         end
         if (region == RGN_VBK && HAS_VBANK) begin
            vbk <= din[0];
         end
         if (region == RGN_SVBK && HAS_WBANK) begin
            svbk <= din[2:0];
         end
      end
   end

   always_comb begin
      in_boot = !boot_done &&
                ((adr[15:8] == 8'h00) ||
                 (IS_CGB && adr >= 16'h0200 && adr <= 16'h08FF));
   end

   always_comb begin
      region = RGN_NONE;
      if (adr <= 16'h7FFF) begin
         region = in_boot ? RGN_BOOT : RGN_CART;
      end else if (adr <= 16'h9FFF) begin
         region = RGN_VRAM;
      end else if (adr <= 16'hBFFF) begin
         region = RGN_CART;
      end else if (adr <= 16'hFDFF) begin
         region = RGN_RAM;
      end else if (adr <= 16'hFE9F) begin
         region = RGN_OAM;
      end else if (adr <= 16'hFEFF) begin
         region = RGN_NONE;
      end else if (adr == 16'hFF50) begin
         region = RGN_BOOTOFF;
      end else if (IS_CGB && adr == 16'hFF4F) begin
         region = RGN_VBK;
      end else if (IS_CGB && adr == 16'hFF70) begin
         region = RGN_SVBK;
      end else if (adr >= 16'hFF80 && adr <= 16'hFFFE) begin
         region = RGN_HRAM;
      end else begin
         region = RGN_IO;
      end
   end

   always_comb begin
      fenced = (region == RGN_BOOT) || (region == RGN_CART) ||
               (region == RGN_VRAM) || (region == RGN_RAM) ||
               (region == RGN_OAM);
   end

   always_comb begin
      sel_bootrom   = 1'b0;
      sel_cartridge = 1'b0;
      sel_vram      = 1'b0;
      sel_ram       = 1'b0;
      sel_oam       = 1'b0;
      sel_hram      = 1'b0;
      sel_io        = 1'b0;
      if (reset && !(dma_active && fenced)) begin
         case (region)
            RGN_BOOT: sel_bootrom   = 1'b1;
            RGN_CART: sel_cartridge = 1'b1;
            RGN_VRAM: sel_vram      = 1'b1;
            RGN_RAM:  sel_ram       = 1'b1;
            RGN_OAM:  sel_oam       = 1'b1;
            RGN_HRAM: sel_hram      = 1'b1;
            RGN_IO:   sel_io        = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus_conflict = reset && dma_active && fenced && (rd || wr);
   end

   // A simultaneous rd+wr is treated as a write, so it never drives the read bus.
   always_comb begin
      dout_en = reset && rd && !wr &&
                ((region == RGN_VBK) || (region == RGN_SVBK));
      dout    = 8'hFF;
      if (reset) begin
         if (region == RGN_VBK) begin
            dout = {7'h7F, vbk};
         end else if (region == RGN_SVBK) begin
            dout = {5'h1F, svbk};
         end
      end
   end

   // adr[12] picks the switchable upper 4 KiB in both C000 and its E000 mirror.
   always_comb begin
      ram_bank = 3'd0;
      if (region == RGN_RAM && adr[12]) begin
         if (HAS_WBANK) begin
            ram_bank = (svbk == 3'd0) ? 3'd1 : svbk;
         end else begin
            ram_bank = 3'd1;
         end
      end
   end

   assign vram_bank = vbk;

endmodule
